// File: rtl/memctrl_pkg.sv
// Shared definitions for the burst SRAM controller: state encoding,
// default geometry and the SRAM strobe bundle.
package memctrl_pkg;

   localparam int unsigned DEF_AW        = 16;
   localparam int unsigned DEF_DW        = 8;
   localparam int unsigned DEF_LW        = 4;
   localparam int unsigned RD_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   // Active-low SRAM strobes, kept together so one flop group drives all three
   typedef struct packed {
      logic csb;
      logic web;
      logic oeb;
   } mem_strb_t;

   localparam mem_strb_t STRB_NONE = '{csb: 1'b1, web: 1'b1, oeb: 1'b1};
   localparam mem_strb_t STRB_WR   = '{csb: 1'b0, web: 1'b0, oeb: 1'b1};
   localparam mem_strb_t STRB_RD   = '{csb: 1'b0, web: 1'b1, oeb: 1'b0};

endpackage

// File: rtl/memctrl_rdfifo.sv
// Small read-return FIFO with registered head data, valid flag and occupancy.
// Depth must be a power of two so the pointers wrap naturally.
module memctrl_rdfifo
   import memctrl_pkg::*;
#(
   parameter int unsigned DW    = DEF_DW,
   parameter int unsigned DEPTH = RD_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DW-1:0]            din,
   input  logic                     pop,
   output logic [DW-1:0]            dout,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          valid_q, valid_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          do_push;
   logic          do_pop;

   // Next storage/pointer state; the head is re-read from the updated storage
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_push  = push && (count_q != CW'(DEPTH));
      do_pop   = pop && valid_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      valid_d = (count_d != '0);
      dout_d  = mem_d[rd_ptr_d];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         dout_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         dout_q   <= dout_d;
      end
   end

   assign dout  = dout_q;
   assign valid = valid_q;
   assign count = count_q;

endmodule

// File: rtl/memctrl_burst.sv
// Burst controller for a single-port synchronous SRAM: accepts write/read
// bursts, sequences the SRAM strobes and buffers read returns in a FIFO.
module memctrl_burst
   import memctrl_pkg::*;
#(
   parameter int unsigned AW = DEF_AW,
   parameter int unsigned DW = DEF_DW,
   parameter int unsigned LW = DEF_LW
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          REQ_VALID,
   output logic          REQ_READY,
   input  logic          REQ_WE,
   input  logic [AW-1:0] REQ_ADDR,
   input  logic [LW-1:0] REQ_LEN,
   input  logic [DW-1:0] WDATA,
   input  logic          WVALID,
   output logic          WREADY,
   output logic [DW-1:0] RDATA,
   output logic          RVALID,
   input  logic          RREADY,
   output logic          BUSY,
   output logic          MEM_CSB,
   output logic          MEM_WEB,
   output logic          MEM_OEB,
   output logic [AW-1:0] MEM_ADDR,
   output logic [DW-1:0] MEM_WDATA,
   input  logic [DW-1:0] MEM_RDATA
);

   localparam int unsigned FCW = $clog2(RD_FIFO_DEPTH) + 1;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic          req_ready_q, req_ready_d;
   logic          wready_q, wready_d;
   logic          busy_q, busy_d;
   mem_strb_t     strb_q, strb_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   // rd_s1: read strobe on the SRAM this cycle; rd_s2: its data returns this cycle
   logic          rd_s1_q, rd_s1_d;
   logic          rd_s2_q, rd_s2_d;

   logic [FCW-1:0] fifo_cnt;
   logic [FCW-1:0] fill;
   logic           can_issue;
   logic           fifo_valid;
   logic [DW-1:0]  fifo_dout;

   // Buffered plus outstanding reads; capped so the FIFO can never overflow
   assign fill      = fifo_cnt + FCW'(rd_s1_q) + FCW'(rd_s2_q);
   assign can_issue = (fill < FCW'(RD_FIFO_DEPTH));

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      strb_d      = STRB_NONE;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rd_s1_d     = 1'b0;
      rd_s2_d     = rd_s1_q;

      case (state_q)
         IDLE: begin
            if (REQ_VALID && req_ready_q) begin
               addr_d  = REQ_ADDR;
               cnt_d   = REQ_LEN;
               state_d = REQ_WE ? WRITE : READ;
            end
         end
         WRITE: begin
            if (WVALID && wready_q) begin
               strb_d      = STRB_WR;
               mem_addr_d  = addr_q;
               mem_wdata_d = WDATA;
               addr_d      = addr_q + AW'(1);
               cnt_d       = cnt_q - LW'(1);
               if (cnt_q == '0) begin
                  state_d = IDLE;
               end
            end
         end
         READ: begin
            if (can_issue) begin
               strb_d     = STRB_RD;
               mem_addr_d = addr_q;
               addr_d     = addr_q + AW'(1);
               cnt_d      = cnt_q - LW'(1);
               rd_s1_d    = 1'b1;
               if (cnt_q == '0) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if ((fifo_cnt == '0) && !rd_s1_q && !rd_s2_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      req_ready_d = (state_d == IDLE);
      wready_d    = (state_d == WRITE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         cnt_q       <= '0;
         req_ready_q <= 1'b0;
         wready_q    <= 1'b0;
         busy_q      <= 1'b0;
         strb_q      <= STRB_NONE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_s1_q     <= 1'b0;
         rd_s2_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         wready_q    <= wready_d;
         busy_q      <= busy_d;
         strb_q      <= strb_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd_s1_q     <= rd_s1_d;
         rd_s2_q     <= rd_s2_d;
      end
   end

   memctrl_rdfifo #(
      .DW    (DW),
      .DEPTH (RD_FIFO_DEPTH)
   ) u_rdfifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (rd_s2_q),
      .din   (MEM_RDATA),
      .pop   (RREADY),
      .dout  (fifo_dout),
      .valid (fifo_valid),
      .count (fifo_cnt)
   );

   assign REQ_READY = req_ready_q;
   assign WREADY    = wready_q;
   assign BUSY      = busy_q;
   assign RVALID    = fifo_valid;
   assign RDATA     = fifo_dout;
   assign MEM_CSB   = strb_q.csb;
   assign MEM_WEB   = strb_q.web;
   assign MEM_OEB   = strb_q.oeb;
   assign MEM_ADDR  = mem_addr_q;
   assign MEM_WDATA = mem_wdata_q;

endmodule
